// File: rtl/dm_ctrl_sync_if.sv
// dm_ctrl_sync_if: request/response channel bundle for the MEM-stage data memory.
// master = pipeline side issuing loads/stores, slave = dm_ctrl_sync.
interface dm_ctrl_sync_if #(
   parameter int ADDR_W = 12
) ();
   // request channel
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   // response channel
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dm_ctrl_sync.sv
// dm_ctrl_sync: registered-read data memory for the MEM stage.
// Byte/half/word loads (sign- or zero-extended) and stores over a valid/ready
// request channel, result returned on a valid/ready response channel.
// Misaligned halfword/word accesses and size 2'b11 are reported on resp_err
// with resp_rdata = 0 and no memory write.
// Optional build macro DM_WAIT_STATES_EN adds a WAIT state of WAIT_CYCLES
// cycles between ACCESS and RESP; without it WAIT_CYCLES is only range-checked.
module dm_ctrl_sync #(
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   dm_ctrl_sync_if.slave bus
);

   localparam int DEPTH = 2 ** (ADDR_W - 2);

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_wait_range
      $error("dm_ctrl_sync: WAIT_CYCLES must lie in 1..15");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
`ifdef DM_WAIT_STATES_EN
      WAIT   = 2'd2,
`endif
      RESP   = 2'd3
   } state_t;

   state_t            state;
   logic              req_ready_r;
   logic              resp_valid_r;
   logic              resp_err_r;
   logic [31:0]       resp_rdata_r;

`ifdef DM_WAIT_STATES_EN
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
   logic [3:0]        wait_cnt;
`endif

   // request captured at the accept edge, consumed in ACCESS
   logic              we_p0;
   logic [1:0]        size_p0;
   logic              uns_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic [31:0]       wdata_p0;

   logic [31:0]       mem [DEPTH];

   logic              accept;
   logic              bad_p0;
   logic              wr_en;
   logic [ADDR_W-3:0] word_idx;
   logic [3:0]        lane_en;
   logic [31:0]       lane_data;
   logic [31:0]       rd_word;
   logic [31:0]       load_val;

   // Sign- or zero-extend a loaded byte to 32 bits.
   function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic uns);
      logic signed [7:0]  sb;
      logic signed [31:0] sx;
      sb = b;
      sx = sb;
      return uns ? {24'h0, b} : sx;
   endfunction

   // Sign- or zero-extend a loaded halfword to 32 bits.
   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic uns);
      logic signed [15:0] sh;
      logic signed [31:0] sx;
      sh = h;
      sx = sh;
      return uns ? {16'h0, h} : sx;
   endfunction

   // Halfwords need an even address, words a 4-byte aligned one; size 11 never succeeds.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return lo[0];
         2'b10:   return lo != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   assign accept   = (state == IDLE) && bus.req_valid && req_ready_r;
   assign word_idx = addr_p0[ADDR_W-1:2];

   // Lane selection for stores and lane extraction/extension for loads.
   always_comb begin
      bad_p0    = misaligned(size_p0, addr_p0[1:0]);
      rd_word   = mem[word_idx];
      lane_en   = 4'b0000;
      lane_data = wdata_p0;
      load_val  = 32'h0;
      case (size_p0)
         2'b00: begin
            lane_en   = 4'b0001 << addr_p0[1:0];
            lane_data = {4{wdata_p0[7:0]}};
            load_val  = ext_byte(rd_word[{addr_p0[1:0], 3'b000} +: 8], uns_p0);
         end
         2'b01: begin
            lane_en   = addr_p0[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata_p0[15:0]}};
            load_val  = ext_half(addr_p0[1] ? rd_word[31:16] : rd_word[15:0], uns_p0);
         end
         2'b10: begin
            lane_en   = 4'b1111;
            lane_data = wdata_p0;
            load_val  = rd_word;
         end
         default: begin
            lane_en   = 4'b0000;
            load_val  = 32'h0;
         end
      endcase
      // A reset during ACCESS returns state to IDLE at once, which drops the write.
      wr_en = (state == ACCESS) && we_p0 && !bad_p0;
   end

   // Latch the request fields when the handshake completes.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_p0    <= bus.req_we;
         size_p0  <= bus.req_size;
         uns_p0   <= bus.req_unsigned;
         addr_p0  <= bus.req_addr;
         wdata_p0 <= bus.req_wdata;
      end
   end

   // Commit store byte lanes on the ACCESS edge; untouched lanes keep their value.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
               mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
         end
      end
   end

   // Control FSM with registered handshake and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         req_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'h0;
         resp_err_r   <= 1'b0;
`ifdef DM_WAIT_STATES_EN
         wait_cnt     <= 4'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  req_ready_r <= 1'b0;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               resp_err_r   <= bad_p0;
               resp_rdata_r <= (bad_p0 || we_p0) ? 32'h0 : load_val;
`ifdef DM_WAIT_STATES_EN
               wait_cnt     <= WAIT_LOAD;
               state        <= WAIT;
`else
               resp_valid_r <= 1'b1;
               state        <= RESP;
`endif
            end
`ifdef DM_WAIT_STATES_EN
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  resp_valid_r <= 1'b1;
                  state        <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
`endif
            RESP: begin
               // no new request is taken here; req_ready returns after the handshake
               if (bus.resp_ready) begin
                  resp_valid_r <= 1'b0;
                  req_ready_r  <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: begin
               state        <= IDLE;
               req_ready_r  <= 1'b1;
               resp_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_r;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_rdata = resp_rdata_r;
   assign bus.resp_err   = resp_err_r;

endmodule

// File: tb/tb_dm_ctrl_sync.sv
// tb_dm_ctrl_sync: directed and randomized load/store traffic against a
// byte-array reference memory for dm_ctrl_sync.
module tb_dm_ctrl_sync;
   localparam int ADDR_W = 12;
   localparam int WC     = 3;
`ifdef DM_WAIT_STATES_EN
   localparam int LAT = 2 + WC;
`else
   localparam int LAT = 2;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dm_ctrl_sync_if #(.ADDR_W(ADDR_W)) bus ();

   dm_ctrl_sync #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   logic [7:0] ref_mem [64];   // little-endian byte image of words 0..15

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
   endtask

   function automatic logic ref_err(input logic [1:0] size, input int addr);
      return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input int addr);
      int     n = 1 << size;
      longint v = 0;
      for (int i = 0; i < n; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
      if (!uns && ref_mem[addr + n - 1][7]) v -= (longint'(1) << (8 * n));
      return 32'(v);
   endfunction

   task automatic ref_store(input logic [1:0] size, input int addr, input logic [31:0] wdata);
      int n = 1 << size;
      for (int i = 0; i < n; i++) ref_mem[addr + i] = 8'(wdata >> (8 * i));
   endtask

   // Present a request and return just after the edge that accepts it.
   task automatic send(input logic we, input logic [1:0] size, input logic uns,
                       input int addr, input logic [31:0] wdata);
      int w = 0;
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = ADDR_W'(addr);
      bus.req_wdata    = wdata;
      while (!bus.req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!bus.req_ready) check("req_ready_timeout", {31'b0, bus.req_ready}, 32'd1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   // Wait for the response, optionally stall it, then complete the handshake.
   task automatic collect(input int hold, input logic [31:0] exp_rd, input logic exp_err,
                          output logic [31:0] rdata, output logic err, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.resp_valid && lat < 50);
      if (!bus.resp_valid) check("resp_valid_timeout", {31'b0, bus.resp_valid}, 32'd1);
      rdata = bus.resp_rdata;
      err   = bus.resp_err;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("stall_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
         check("stall_rdata", bus.resp_rdata, exp_rd);
         check("stall_err", {31'b0, bus.resp_err}, {31'b0, exp_err});
         check("stall_req_ready", {31'b0, bus.req_ready}, 32'd0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready = 1'b0;
      check("post_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      check("post_req_ready", {31'b0, bus.req_ready}, 32'd1);
   endtask

   task automatic xact(input logic we, input logic [1:0] size, input logic uns, input int addr,
                       input logic [31:0] wdata, input int hold, output logic [31:0] rdata);
      logic        exp_err;
      logic [31:0] exp_rd;
      logic        got_err;
      int          lat;
      exp_err = ref_err(size, addr);
      exp_rd  = (we || exp_err) ? 32'h0 : ref_load(size, uns, addr);
      send(we, size, uns, addr, wdata);
      collect(hold, exp_rd, exp_err, rdata, got_err, lat);
      check($sformatf("rdata@%0h", addr), rdata, exp_rd);
      check($sformatf("err@%0h", addr), {31'b0, got_err}, {31'b0, exp_err});
      check("latency", 32'(lat), 32'(LAT));
      if (we && !exp_err) ref_store(size, addr, wdata);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired after %0d/%0d checks", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int          w;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = 32'h0;
      bus.resp_ready   = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
      check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      check("rst_rdata", bus.resp_rdata, 32'h0);
      check("rst_err", {31'b0, bus.resp_err}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // give the modelled window a known zero image
      for (int a = 0; a < 64; a += 4) xact(1'b1, 2'd2, 1'b0, a, 32'h0, 0, rd);

      // word store then word load
      xact(1'b1, 2'd2, 1'b0, 'h10, 32'h8081_F0FF, 0, rd);
      xact(1'b0, 2'd2, 1'b0, 'h10, 32'h0, 0, rd);
      check("t1_lw", rd, 32'h8081_F0FF);

      // sub-word loads, signed and unsigned
      xact(1'b0, 2'd0, 1'b0, 'h10, 32'h0, 0, rd);  check("t2_lb", rd, 32'hFFFF_FFFF);
      xact(1'b0, 2'd0, 1'b1, 'h11, 32'h0, 0, rd);  check("t2_lbu", rd, 32'h0000_00F0);
      xact(1'b0, 2'd1, 1'b0, 'h12, 32'h0, 0, rd);  check("t2_lh", rd, 32'hFFFF_8081);
      xact(1'b0, 2'd1, 1'b1, 'h12, 32'h0, 0, rd);  check("t2_lhu", rd, 32'h0000_8081);

      // byte store leaves the other lanes intact
      xact(1'b1, 2'd0, 1'b0, 'h13, 32'h0000_005A, 0, rd);
      xact(1'b0, 2'd2, 1'b0, 'h10, 32'h0, 0, rd);  check("t3_lw", rd, 32'h5A81_F0FF);

      // error cases write nothing
      xact(1'b1, 2'd1, 1'b0, 'h11, 32'hDEAD_BEEF, 0, rd);
      xact(1'b0, 2'd2, 1'b0, 'h12, 32'h0, 0, rd);
      xact(1'b1, 2'd3, 1'b0, 'h10, 32'hDEAD_BEEF, 0, rd);
      xact(1'b0, 2'd2, 1'b0, 'h10, 32'h0, 0, rd);  check("t4_lw", rd, 32'h5A81_F0FF);

      // consumer stall
      xact(1'b0, 2'd2, 1'b0, 'h10, 32'h0, 5, rd);

      // reset before the commit edge drops the store
      send(1'b1, 2'd2, 1'b0, 'h20, 32'h1234_5678);
      #2 rst_n = 1'b0;
      #1;
      check("t6_req_ready", {31'b0, bus.req_ready}, 32'd1);
      check("t6_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      check("t6_rdata", bus.resp_rdata, 32'h0);
      check("t6_err", {31'b0, bus.resp_err}, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      xact(1'b0, 2'd2, 1'b0, 'h20, 32'h0, 0, rd);  check("t6_dropped", rd, 32'h0);

      // reset after the commit edge keeps the store
      send(1'b1, 2'd2, 1'b0, 'h24, 32'hCAFE_F00D);
      w = 0;
      while (!bus.resp_valid && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("t6b_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
      rst_n = 1'b0;
      ref_store(2'd2, 'h24, 32'hCAFE_F00D);
      #1 check("t6b_rst_valid", {31'b0, bus.resp_valid}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      xact(1'b0, 2'd2, 1'b0, 'h24, 32'h0, 0, rd);  check("t6b_kept", rd, 32'hCAFE_F00D);

      // randomized traffic over the modelled window
      for (int t = 0; t < 150; t++) begin
         logic       we;
         logic [1:0] size;
         logic       uns;
         int         addr;
         int         hold;
         we   = 1'($urandom_range(0, 1));
         size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         uns  = 1'($urandom_range(0, 1));
         addr = $urandom_range(0, 63);
         if (size != 2'd3 && $urandom_range(0, 4) != 0) addr = addr & ~((1 << size) - 1);
         hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         xact(we, size, uns, addr, $urandom, hold, rd);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
